// File: rtl/serial_flag_gen.sv
// serial_flag_gen: multi-cycle Zero/Neg/Ofl flag producer.
// Adds A+B or A+~B+1 CHUNK bits per cycle, LSB-first, with a one-bit ripple
// carry held between slices. The flags are registered on the last slice and
// stay stable until the next result. A start/busy/done handshake talks to the
// pipeline stall logic.
module serial_flag_gen #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Zero,
    output logic             Neg,
    output logic             Ofl,
    output logic             err
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic             r_sub;
    logic             r_nz;
    logic [CW-1:0]    r_cnt;

    logic             r_zero;
    logic             r_neg;
    logic             r_ofl;
    logic             r_err;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [CHUNK:0]   w_slice;
    logic             w_c_in_msb;
    logic             w_s_msb;
    logic             w_cout;
    logic             w_slice_nz;
    logic             w_zero;
    logic             w_neg;
    logic             w_ofl;

    // A request is taken in IDLE and in DONE (back-to-back); in RUN it is an error.
    assign w_run    = (r_state == S_RUN);
    assign w_accept = start && !w_run;
    assign w_last   = w_run && (r_cnt == LAST);

    // One CHUNK-wide slice of the sum plus its carry out (CHUNK+1 bits).
    assign w_slice = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, r_carry};

    // Carry into the slice MSB recovered from the sum bit and its two addends;
    // on the last slice this is the carry into bit WIDTH-1.
    assign w_c_in_msb = w_slice[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
    assign w_s_msb    = w_slice[CHUNK-1];
    assign w_cout     = w_slice[CHUNK];
    assign w_slice_nz = |w_slice[CHUNK-1:0];

    // Final flag values; only meaningful while the last slice is being added.
    assign w_zero = ~(r_nz | w_slice_nz);
    assign w_ofl  = r_sub ? (w_c_in_msb ^ w_cout) : w_cout;
    assign w_neg  = r_sub ? (w_s_msb ^ w_ofl) : w_s_msb;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for N slices, DONE for one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and slice-by-slice shifting with ripple carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_nz    <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
            r_a     <= A;
            r_b     <= sub ? ~B : B;
            r_carry <= sub;
            r_sub   <= sub;
            r_nz    <= 1'b0;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_cout;
            r_nz    <= r_nz | w_slice_nz;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Result flags: updated only on the edge that enters DONE, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ofl  <= 1'b0;
        end else if (w_last) begin
            r_zero <= w_zero;
            r_neg  <= w_neg;
            r_ofl  <= w_ofl;
        end
    end

    // Collision pulse: a start seen while running is dropped and flagged next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= start && w_run;
        end
    end

    assign Zero = r_zero;
    assign Neg  = r_neg;
    assign Ofl  = r_ofl;
    assign err  = r_err;

endmodule

// File: tb/tb_serial_flag_gen.sv
// tb_serial_flag_gen: directed checks of serial_flag_gen with default
// parameters (WIDTH=16, CHUNK=4, 4 slice cycles, done 5 cycles after start).
// Inputs are driven and outputs sampled on the falling edge.
module tb_serial_flag_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic        Zero;
    logic        Neg;
    logic        Ofl;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_flag_gen #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Zero  (Zero),
        .Neg   (Neg),
        .Ofl   (Ofl),
        .err   (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge: presents one request for a cycle, then waits
    // (bounded) for done. cyc = falling edges until done, bcyc = cycles with busy.
    task automatic launch_and_wait(input logic s, input logic [15:0] a, input logic [15:0] b,
                                   output int cyc, output int bcyc);
        sub   = s;
        A     = a;
        B     = b;
        start = 1'b1;
        cyc   = 0;
        bcyc  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (busy) bcyc++;
            if (done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                          input logic [15:0] b, input logic ez, input logic en, input logic eo);
        int cyc;
        int bcyc;
        launch_and_wait(s, a, b, cyc, bcyc);
        chk({tag, ".latency"}, cyc, 5);
        chk({tag, ".busy_cycles"}, bcyc, 4);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy_at_done"}, busy, 0);
        chk({tag, ".Zero"}, Zero, ez);
        chk({tag, ".Neg"}, Neg, en);
        chk({tag, ".Ofl"}, Ofl, eo);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 0);
        $display("op %s sub=%0d A=%h B=%h lat=%0d Z=%0d N=%0d O=%0d", tag, s, a, b, cyc, Zero, Neg, Ofl);
    endtask

    initial begin
        int cyc;
        int bcyc;
        int ndone;

        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.Zero", Zero, 0);
        chk("rst.Neg",  Neg,  0);
        chk("rst.Ofl",  Ofl,  0);
        chk("rst.err",  err,  0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy", busy, 0);
        $display("reset checked");

        // Equal compare, signed-overflow compares, carry-mode adds.
        run_op("eq",      1'b1, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0);
        run_op("ovf_lt",  1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        run_op("ovf_gt",  1'b1, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);
        run_op("add_wrap",1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1);
        run_op("add_msb", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);

        // Busy collision: second request two cycles in is dropped and flagged.
        sub = 1'b1; A = 16'h0003; B = 16'h0007; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); sub = 1'b0; A = 16'h0000; B = 16'h0000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("coll.err", err, 1);
        chk("coll.busy", busy, 1);
        @(negedge clk);
        chk("coll.err_pulse", err, 0);
        @(negedge clk);
        chk("coll.done", done, 1);
        chk("coll.Zero", Zero, 0);
        chk("coll.Neg",  Neg,  1);
        chk("coll.Ofl",  Ofl,  0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("coll.extra_done", ndone, 0);
        $display("op collision 3-7 with dropped 0+0 Z=%0d N=%0d O=%0d extra_done=%0d", Zero, Neg, Ofl, ndone);

        // Back-to-back: second request presented in the DONE cycle.
        launch_and_wait(1'b1, 16'h0002, 16'h0009, cyc, bcyc);
        chk("b2b1.latency", cyc, 5);
        chk("b2b1.Neg",  Neg,  1);
        chk("b2b1.Zero", Zero, 0);
        sub = 1'b0; A = 16'hFFFF; B = 16'h0001; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("b2b2.busy_no_gap", busy, 1);
        chk("b2b2.done_low", done, 0);
        chk("b2b2.Neg_held", Neg, 1);
        chk("b2b2.Zero_held", Zero, 0);
        cyc = 1;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
            cyc++;
            if (!done && cyc == 4) chk("b2b2.Ofl_held", Ofl, 0);
        end
        chk("b2b2.latency", cyc, 5);
        chk("b2b2.Zero", Zero, 1);
        chk("b2b2.Neg",  Neg,  0);
        chk("b2b2.Ofl",  Ofl,  1);
        $display("op back-to-back 2-9 then FFFF+1 lat=%0d Z=%0d N=%0d O=%0d", cyc, Zero, Neg, Ofl);
        @(negedge clk);

        // Reset in the second RUN cycle while previous Zero=1.
        chk("mid.pre_Zero", Zero, 1);
        sub = 1'b1; A = 16'h0005; B = 16'h0006; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid.busy", busy, 0);
        chk("mid.done", done, 0);
        chk("mid.Zero", Zero, 0);
        chk("mid.Neg",  Neg,  0);
        chk("mid.Ofl",  Ofl,  0);
        chk("mid.err",  err,  0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid.no_done", ndone, 0);
        $display("op reset mid-run, done pulses after=%0d", ndone);
        run_op("after_rst", 1'b1, 16'h0003, 16'h0007, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
